// File: rtl/echo_mac_scheduler_pkg.sv
// echo_mac_scheduler_pkg: shared state/op encodings and period helper for the echo MAC scheduler
package echo_mac_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, FILT, UPD} state_t;
  localparam logic OP_FILT = 1'b0;
  localparam logic OP_UPD = 1'b1;
  localparam int TAPS_DEF = 4;
  function automatic int min_cycle(input int taps);
    return 2 * taps + 1;
  endfunction
endpackage

// File: rtl/sample_divider.sv
// sample_divider: free-running sample-period counter with a one-clock strobe at count 0
module sample_divider
  import echo_mac_scheduler_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] cycle,
  output logic             strobe
);
  // the minimum period saturates at the largest value the counter can hold
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] MINC = CNT_W'(min_cycle(TAPS) > MAXC ? MAXC : min_cycle(TAPS));
  logic [CNT_W-1:0] count, per, cyc_eff;
  assign cyc_eff = cycle < MINC ? MINC : cycle;
  assign strobe = count == '0 && enable;
  always_ff @(posedge clk)
    if (reset) begin
      count <= '0;
      per <= cyc_eff;
    end else if (enable) begin
      count <= count == per - 1'b1 ? '0 : count + 1'b1;
      if (count == per - 1'b1) per <= cyc_eff;
    end
endmodule

// File: rtl/echo_mac_scheduler.sv
// echo_mac_scheduler: per-sample FILT/UPD MAC sequencer with sticky overrun detection
module echo_mac_scheduler
  import echo_mac_scheduler_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int CNT_W = 5,
  localparam int TW = TAPS > 1 ? $clog2(TAPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] cycle,
  input  logic             upd_en,
  input  logic             ovr_clr,
  output logic             sample_strobe,
  output logic             mac_valid,
  output logic             mac_op,
  output logic [TW-1:0]    mac_tap,
  output logic             mac_clear,
  output logic             err_valid,
  output logic             done,
  output logic             busy,
  output logic             overrun
);
  state_t state;
  logic upd_q, last;
  sample_divider #(.TAPS(TAPS), .CNT_W(CNT_W)) u_div (
    .clk(clk), .reset(reset), .enable(enable), .cycle(cycle), .strobe(sample_strobe)
  );
  assign last = mac_tap == TW'(TAPS - 1);
  assign busy = state != IDLE;
  assign mac_valid = busy;
  assign mac_op = state == UPD ? OP_UPD : OP_FILT;
  assign mac_clear = state == FILT && mac_tap == '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      upd_q <= 1'b0;
      mac_tap <= '0;
      err_valid <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      done <= 1'b0;
      overrun <= (sample_strobe && busy) || (overrun && !ovr_clr);
      if (state == IDLE) begin
        if (sample_strobe) begin
          state <= FILT;
          upd_q <= upd_en;
        end
      end else if (last) begin
        mac_tap <= '0;
        err_valid <= state == FILT;
        done <= state == UPD || !upd_q;
        state <= state == FILT && upd_q ? UPD : IDLE;
      end else mac_tap <= mac_tap + 1'b1;
    end
endmodule

// File: tb/tb_echo_mac_scheduler.sv
// tb_echo_mac_scheduler: table vectors, directed corner cases and a randomized reference-model run
module tb_echo_mac_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, enable, upd_en, ovr_clr;
  logic [4:0] cycle;
  logic strobe, valid, op, clr, err, done, busy, ovr;
  logic [1:0] tap;
  logic reset8, en8, upd8, clr8;
  logic [3:0] cycle8;
  logic s8, v8, o8, c8, e8, d8, b8, ov8;
  logic [2:0] t8;
  int checks = 0, failures = 0;

  echo_mac_scheduler #(.TAPS(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cycle(cycle), .upd_en(upd_en), .ovr_clr(ovr_clr),
    .sample_strobe(strobe), .mac_valid(valid), .mac_op(op), .mac_tap(tap), .mac_clear(clr),
    .err_valid(err), .done(done), .busy(busy), .overrun(ovr)
  );
  // minimum period 17 cannot fit a 4-bit counter, so strobes arrive every 15 clocks
  echo_mac_scheduler #(.TAPS(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset8), .enable(en8), .cycle(cycle8), .upd_en(upd8), .ovr_clr(clr8),
    .sample_strobe(s8), .mac_valid(v8), .mac_op(o8), .mac_tap(t8), .mac_clear(c8),
    .err_valid(e8), .done(d8), .busy(b8), .overrun(ov8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input logic s, v, o, input int t, input logic c, e, d, b);
    chk({tag, " strobe"}, strobe, s);
    chk({tag, " valid"}, valid, v);
    chk({tag, " op"}, op, o);
    chk({tag, " tap"}, tap, t);
    chk({tag, " clear"}, clr, c);
    chk({tag, " err_valid"}, err, e);
    chk({tag, " done"}, done, d);
    chk({tag, " busy"}, busy, b);
  endtask

  function automatic int clampc(input int c, input int taps, input int cw);
    int m = 2 * taps + 1;
    if (m > (1 << cw) - 1) m = (1 << cw) - 1;
    return c < m ? m : c;
  endfunction

  typedef struct {
    logic rst, en, upd;
    logic s, v, o;
    int t;
    logic c, e, d, b;
  } vec_t;
  vec_t vt[21];

  int m_phase, m_per, m_k, len, e_tap;
  bit m_act, m_upd, m_ovr, bsy, e_s;
  int st[$];
  bit found;

  initial begin
    vt[0]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    vt[2]  = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    vt[3]  = '{0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 1};
    vt[4]  = '{0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 1};
    vt[5]  = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1};
    vt[6]  = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    vt[7]  = '{0, 1, 0, 0, 1, 1, 2, 0, 0, 0, 1};
    vt[8]  = '{0, 1, 0, 0, 1, 1, 3, 0, 0, 0, 1};
    vt[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[13] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1};
    vt[14] = '{0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1};
    vt[15] = '{0, 1, 1, 0, 1, 0, 2, 0, 0, 0, 1};
    vt[16] = '{0, 1, 1, 0, 1, 0, 3, 0, 0, 0, 1};
    vt[17] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vt[18] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[19] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[20] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    reset = 1; enable = 1; upd_en = 0; ovr_clr = 0; cycle = 12;
    reset8 = 1; en8 = 1; upd8 = 1; clr8 = 0; cycle8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset overrun", ovr, 0);
    chk("reset tap", tap, 0);
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      reset = vt[i].rst; enable = vt[i].en; upd_en = vt[i].upd;
      #1;
      chk_dut($sformatf("vec%0d", i), vt[i].s, vt[i].v, vt[i].o, vt[i].t, vt[i].c, vt[i].e, vt[i].d, vt[i].b);
    end

    // period clamp: cycle=4 gives strobes every 9 clocks, first right after reset
    @(negedge clk); reset = 1; cycle = 4; upd_en = 0;
    @(negedge clk); reset = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (strobe) st.push_back(k);
    end
    chk("clamp first strobe", st.size() > 0 ? st[0] : -1, 0);
    chk("clamp gap1", st.size() > 1 ? st[1] - st[0] : -1, 9);
    chk("clamp gap2", st.size() > 2 ? st[2] - st[1] : -1, 9);

    // reset while FILT tap 2 is issued aborts without done/err_valid
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      found = valid && !op && tap == 2;
    end
    chk("reach FILT tap2", found, 1);
    reset = 1;
    @(negedge clk);
    #1;
    chk("abort valid", valid, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort err_valid", err, 0);
    @(negedge clk); reset = 0;

    // overrun on the saturated-period instance
    @(negedge clk); reset8 = 0;
    for (int k = 0; k < 48; k++) begin
      if (k > 0) @(negedge clk);
      clr8 = (k == 20 || k == 45);
      #1;
      if (k == 0) chk("ovr strobe0", s8, 1);
      if (k == 15) begin
        chk("ovr strobe15", s8, 1); chk("ovr busy15", b8, 1);
        chk("ovr tap15", t8, 6); chk("ovr op15", o8, 1); chk("ovr flag15", ov8, 0);
      end
      if (k == 16) begin chk("ovr flag16", ov8, 1); chk("ovr tap16", t8, 7); chk("ovr op16", o8, 1); end
      if (k == 17) begin chk("ovr done17", d8, 1); chk("ovr flag17", ov8, 1); end
      if (k == 20) chk("ovr sticky20", ov8, 1);
      if (k == 21) chk("ovr cleared21", ov8, 0);
      if (k == 31) begin chk("ovr next clear", c8, 1); chk("ovr next valid", v8, 1); chk("ovr next err", e8, 0); end
      if (k == 44) chk("ovr flag44", ov8, 0);
      if (k == 46) chk("ovr set wins", ov8, 1);
    end

    // randomized run against the offset-based reference model
    @(negedge clk); reset = 1; ovr_clr = 0; cycle = 12;
    @(posedge clk);
    m_phase = 0; m_per = clampc(cycle, 4, 5); m_act = 0; m_ovr = 0; m_k = 0; m_upd = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      reset = $urandom_range(0, 99) < 2;
      enable = $urandom_range(0, 9) != 0;
      upd_en = 1'($urandom_range(0, 1));
      ovr_clr = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 19) == 0) cycle = 5'($urandom_range(0, 31));
      #1;
      len = m_upd ? 8 : 4;
      bsy = m_act && m_k >= 1 && m_k <= len;
      e_s = enable && m_phase == 0;
      e_tap = bsy ? (m_k - 1) % 4 : 0;
      chk_dut("rand", e_s, bsy, bsy && m_k > 4, e_tap, bsy && m_k == 1,
              m_act && m_k == 5, m_act && m_k == len + 1, bsy);
      chk("rand overrun", ovr, m_ovr);
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_per = clampc(cycle, 4, 5); m_act = 0; m_ovr = 0; m_k = 0;
      end else begin
        m_ovr = (e_s && bsy) || (m_ovr && !ovr_clr);
        if (e_s && !bsy) begin m_act = 1; m_k = 1; m_upd = upd_en; end
        else if (m_act && m_k <= len) m_k++;
        else m_act = 0;
        if (enable) begin
          if (m_phase == m_per - 1) begin m_phase = 0; m_per = clampc(cycle, 4, 5); end
          else m_phase++;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
